// File: rtl/cpi_rx_packer.sv
// cpi_rx_packer: packs 8/16-bit camera samples into 32-bit little-endian
// words for the uDMA RX linear channel. On end of frame it emits a zero-padded
// partial word. It also counts the words of the current and the last frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_FILL  | accepting samples into acc; a completing sample loads the output
// ST_FLUSH | one residue byte is left after a halfword overflowed the last word
//
// Invariant: acc byte lanes at or above fill are always zero. Because of this,
// a partial last word has zero upper lanes without any extra masking.
module cpi_rx_packer #(
    parameter int WCNT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    input  logic [15:0]           in_data_i,
    input  logic [1:0]            in_datasize_i,
    input  logic                  in_last_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [31:0]           out_data_o,
    output logic [1:0]            out_datasize_o,
    output logic [2:0]            out_bytes_o,
    output logic                  out_last_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  frame_done_o,
    output logic [WCNT_WIDTH-1:0] cur_words_o,
    output logic [WCNT_WIDTH-1:0] last_words_o
);

    typedef enum logic {ST_FILL, ST_FLUSH} state_t;

    state_t      state;
    logic [31:0] acc;
    logic [1:0]  fill;

    logic [2:0]  size;
    logic [2:0]  sum;
    logic        completes;
    logic        overflow;
    logic        slot_free;
    logic        accept;
    logic        out_hs;
    logic [47:0] new_bytes;
    logic [47:0] merged;

    assign out_datasize_o = 2'b10;

    // Sample sizing, lane merge and the accept/backpressure decision.
    // rstn_i gates in_ready_o so that it reads 0 while reset is asserted.
    always_comb begin
        size       = (in_datasize_i == 2'b00) ? 3'd1 : 3'd2;
        sum        = {1'b0, fill} + size;
        completes  = sum[2] | in_last_i;
        overflow   = (sum > 3'd4);
        slot_free  = !out_valid_o | out_ready_i;
        in_ready_o = rstn_i & cfg_en_i & !cfg_clr_i & (state == ST_FILL)
                     & (!completes | slot_free);
        accept     = in_valid_i & in_ready_o;
        out_hs     = out_valid_o & out_ready_i;
        new_bytes  = (size == 3'd1) ? {40'd0, in_data_i[7:0]} : {32'd0, in_data_i};
        merged     = {16'd0, acc} | (new_bytes << {fill, 3'b000});
    end

    // Accumulator, output register, FSM and frame statistics.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= ST_FILL;
            acc          <= '0;
            fill         <= '0;
            out_data_o   <= '0;
            out_bytes_o  <= '0;
            out_last_o   <= 1'b0;
            out_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            cur_words_o  <= '0;
            last_words_o <= '0;
        end else if (cfg_clr_i) begin
            state        <= ST_FILL;
            acc          <= '0;
            fill         <= '0;
            out_valid_o  <= 1'b0;
            out_last_o   <= 1'b0;
            frame_done_o <= 1'b0;
            cur_words_o  <= '0;
        end else begin
            frame_done_o <= 1'b0;
            if (out_hs) begin
                out_valid_o <= 1'b0;
                out_last_o  <= 1'b0;
                if (out_last_o) begin
                    frame_done_o <= 1'b1;
                    last_words_o <= cur_words_o + WCNT_WIDTH'(1);
                    cur_words_o  <= '0;
                end else begin
                    cur_words_o  <= cur_words_o + WCNT_WIDTH'(1);
                end
            end
            // A reload in the same cycle as a handshake overrides the clear
            // above, so back-to-back words leave no bubble on out_valid_o.
            if (accept) begin
                if (completes) begin
                    out_data_o  <= merged[31:0];
                    out_bytes_o <= sum[2] ? 3'd4 : sum;
                    out_valid_o <= 1'b1;
                    if (in_last_i && overflow) begin
                        out_last_o <= 1'b0;
                        acc        <= {24'd0, merged[39:32]};
                        fill       <= 2'd1;
                        state      <= ST_FLUSH;
                    end else if (in_last_i) begin
                        out_last_o <= 1'b1;
                        acc        <= '0;
                        fill       <= '0;
                    end else begin
                        out_last_o <= 1'b0;
                        acc        <= {24'd0, merged[39:32]};
                        fill       <= sum[1:0];
                    end
                end else begin
                    acc  <= merged[31:0];
                    fill <= sum[1:0];
                end
            end else if (state == ST_FLUSH && cfg_en_i && slot_free) begin
                out_data_o  <= {24'd0, acc[7:0]};
                out_bytes_o <= 3'd1;
                out_last_o  <= 1'b1;
                out_valid_o <= 1'b1;
                acc         <= '0;
                fill        <= '0;
                state       <= ST_FILL;
            end
        end
    end

endmodule
